reg_file_sb: RTL and testbench

Parametrised, scoreboarded register file for the datapath. It is the successor to the basic two-read/one-write register file. It adds four things: uniform optional zero-register semantics on both read ports, per-register busy (scoreboard) bits for issue-stage hazard checks, a sequential bulk-clear engine, and optional write-to-read bypass. It sits between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/reg_file_sb.sv | 149 ++++++++++++++
 tb/tb_reg_file_sb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Brief    : Two-read / one-write register file with per-register busy
//            (scoreboard) bits, optional hard-wired zero register, and a
//            sequential bulk-clear engine (one register per cycle).
//            Optional feature macro: REGFILE_BYPASS_EN. When it is defined,
//            an accepted IDLE write is forwarded to a matching read port in
//            the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int W       = 8,
  parameter int A       = 4,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         WriteEn,
  input  logic [A-1:0] Waddr,
  input  logic [W-1:0] DataIn,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  input  logic         ResvEn,
  input  logic [A-1:0] ResvAddr,
  output logic         BusyA,
  output logic         BusyB,
  input  logic         ClearReq,
  output logic         Ready,
  output logic         ClearDone
);

  localparam int         DEPTH      = 1 << A;
  // Counter value of the final CLEAR cycle; the counter carries one extra
  // bit so the post-increment value 2**A is representable.
  localparam logic [A:0] C_LAST_IDX = (A + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [A:0]         cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [W-1:0]       regs_q [DEPTH];
  logic [W-1:0]       regs_d [DEPTH];

  logic               w_idle;
  logic               w_wr_ok;
  logic               w_resv_ok;
  logic               w_rd_a_zero;
  logic               w_rd_b_zero;

  // Qualified strobes: only accepted in IDLE and never aimed at a hard-wired r0.
  assign w_idle      = (state_q == IDLE);
  assign w_wr_ok     = w_idle && WriteEn && !(ZERO_R0 && (Waddr == '0));
  assign w_resv_ok   = w_idle && ResvEn  && !(ZERO_R0 && (ResvAddr == '0));
  assign w_rd_a_zero = ZERO_R0 && (RaddrA == '0);
  assign w_rd_b_zero = ZERO_R0 && (RaddrB == '0);

  assign Ready     = w_idle;
  assign ClearDone = done_q;

  // Next-state logic: writeback, reservations, clear sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end

    if (state_q == IDLE) begin
      if (w_wr_ok) begin
        regs_d[Waddr] = DataIn;
        busy_d[Waddr] = 1'b0;
      end
      // Applied after the write so a same-address reservation leaves busy set.
      if (w_resv_ok) begin
        busy_d[ResvAddr] = 1'b1;
      end
      // Entering CLEAR drops every outstanding reservation on this edge.
      if (ClearReq) begin
        state_d = CLEAR;
        cnt_d   = '0;
        busy_d  = '0;
      end
    end else begin
      regs_d[cnt_q[A-1:0]] = '0;
      cnt_d                = cnt_q + 1'b1;
      if (cnt_q == C_LAST_IDX) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational read ports, with optional same-cycle write forwarding.
  always_comb begin
    DataOutA = regs_q[RaddrA];
    DataOutB = regs_q[RaddrB];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && (Waddr == RaddrA)) begin
      DataOutA = DataIn;
    end
    if (w_wr_ok && (Waddr == RaddrB)) begin
      DataOutB = DataIn;
    end
`endif
    if (w_rd_a_zero) begin
      DataOutA = '0;
    end
    if (w_rd_b_zero) begin
      DataOutB = '0;
    end
  end

  // Busy lookups are never forwarded; r0 always reports not-busy when hard-wired.
  assign BusyA = busy_q[RaddrA] && !w_rd_a_zero;
  assign BusyB = busy_q[RaddrB] && !w_rd_b_zero;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Brief    : Scoreboard bench for reg_file_sb (W=8, A=4, ZERO_R0=1).
//            Stimulus queues the expected outputs for each cycle it drives;
//            a monitor on the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       WriteEn;
  logic [3:0] Waddr;
  logic [7:0] DataIn;
  logic [3:0] RaddrA;
  logic [3:0] RaddrB;
  logic [7:0] DataOutA;
  logic [7:0] DataOutB;
  logic       ResvEn;
  logic [3:0] ResvAddr;
  logic       BusyA;
  logic       BusyB;
  logic       ClearReq;
  logic       Ready;
  logic       ClearDone;

  reg_file_sb #(.W(8), .A(4), .ZERO_R0(1'b1)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .WriteEn  (WriteEn),
    .Waddr    (Waddr),
    .DataIn   (DataIn),
    .RaddrA   (RaddrA),
    .RaddrB   (RaddrB),
    .DataOutA (DataOutA),
    .DataOutB (DataOutB),
    .ResvEn   (ResvEn),
    .ResvAddr (ResvAddr),
    .BusyA    (BusyA),
    .BusyB    (BusyB),
    .ClearReq (ClearReq),
    .Ready    (Ready),
    .ClearDone(ClearDone)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] da;
    logic [7:0] db;
    logic       ba;
    logic       bb;
    logic       rdy;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != cyc || DataOutA !== e.da || DataOutB !== e.db ||
          BusyA !== e.ba || BusyB !== e.bb || Ready !== e.rdy || ClearDone !== e.dn) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got A=%02h B=%02h bA=%b bB=%b rdy=%b done=%b, want A=%02h B=%02h bA=%b bB=%b rdy=%b done=%b",
                 e.name, cyc, DataOutA, DataOutB, BusyA, BusyB, Ready, ClearDone,
                 e.da, e.db, e.ba, e.bb, e.rdy, e.dn);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] da, input logic [7:0] db,
                     input logic ba, input logic bb, input logic rdy, input logic dn);
    exp_t e;
    e.cyc = cyc; e.name = name; e.da = da; e.db = db;
    e.ba = ba; e.bb = bb; e.rdy = rdy; e.dn = dn;
    sb.push_back(e);
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      RaddrA = 4'(i);
      RaddrB = 4'(15 - i);
      chk(name, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  initial begin
    Reset = 1'b0; WriteEn = 1'b0; Waddr = '0; DataIn = '0;
    RaddrA = '0; RaddrB = '0; ResvEn = 1'b0; ResvAddr = '0; ClearReq = 1'b0;

    // Reset, then every location reads zero.
    tick();
    Reset = 1'b1;
    n_checks++;
    if (Ready !== 1'b1 || ClearDone !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_direct: rdy=%b done=%b", Ready, ClearDone);
    end
    read_all_zero("reset_read");

    // Write r5, read on A, r0 on B.
    WriteEn = 1'b1; Waddr = 4'd5; DataIn = 8'hA7; RaddrA = 4'd5; RaddrB = 4'd0;
    chk("wr_r5_same", BYP ? 8'hA7 : 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    WriteEn = 1'b0;
    chk("wr_r5_next", 8'hA7, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    // Write to r0 is discarded.
    WriteEn = 1'b1; Waddr = 4'd0; DataIn = 8'h33; RaddrA = 4'd0; RaddrB = 4'd5;
    chk("wr_r0_same", 8'h00, 8'hA7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    WriteEn = 1'b0;
    chk("wr_r0_next", 8'h00, 8'hA7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Reserve r3, write it two cycles later.
    ResvEn = 1'b1; ResvAddr = 4'd3; RaddrA = 4'd3; RaddrB = 4'd5;
    chk("resv_r3_strobe", 8'h00, 8'hA7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    ResvEn = 1'b0;
    chk("resv_r3_gap", 8'h00, 8'hA7, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    WriteEn = 1'b1; Waddr = 4'd3; DataIn = 8'h11;
    chk("wr_r3_strobe", BYP ? 8'h11 : 8'h00, 8'hA7, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    WriteEn = 1'b0;
    chk("wr_r3_clears_busy", 8'h11, 8'hA7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    // Same-cycle write and reserve: reservation wins.
    WriteEn = 1'b1; Waddr = 4'd3; DataIn = 8'h11; ResvEn = 1'b1; ResvAddr = 4'd3;
    chk("wr_resv_same_strobe", 8'h11, 8'hA7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    WriteEn = 1'b0; ResvEn = 1'b0;
    chk("wr_resv_same_after", 8'h11, 8'hA7, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    // Reservation of r0 is discarded.
    ResvEn = 1'b1; ResvAddr = 4'd0; RaddrB = 4'd0;
    chk("resv_r0_strobe", 8'h11, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    ResvEn = 1'b0;
    chk("resv_r0_after", 8'h11, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();

    // Fill r0..r15 with i+1 (r0 write discarded).
    for (int i = 0; i < 16; i++) begin
      WriteEn = 1'b1; Waddr = 4'(i); DataIn = 8'(i + 1);
      tick();
    end
    WriteEn = 1'b0;
    RaddrA = 4'd15; RaddrB = 4'd3;
    chk("fill_r15_r3", 8'h10, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    RaddrA = 4'd0; RaddrB = 4'd1;
    chk("fill_r0_r1", 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Bulk clear; a write to r7 during CLEAR is dropped.
    RaddrA = 4'd7; RaddrB = 4'd15; ClearReq = 1'b1;
    chk("clear_req", 8'h08, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    ClearReq = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) begin
        WriteEn = 1'b1; Waddr = 4'd7; DataIn = 8'hEE;
      end else begin
        WriteEn = 1'b0;
      end
      chk($sformatf("clearing_%0d", k), (k > 7) ? 8'h00 : 8'h08, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (Ready !== (k == 15)) begin
        n_fail++;
        $display("FAIL clear_ready_direct_%0d: rdy=%b", k, Ready);
      end
    end
    WriteEn = 1'b0;
    chk("clear_done", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("clear_done_once", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    read_all_zero("after_clear");

    // Reset in the middle of a clear.
    WriteEn = 1'b1; Waddr = 4'd5; DataIn = 8'h55;
    tick();
    Waddr = 4'd12; DataIn = 8'hCC;
    tick();
    WriteEn = 1'b0;
    RaddrA = 4'd12; RaddrB = 4'd5; ClearReq = 1'b1;
    chk("clear2_req", 8'hCC, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    ClearReq = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) Reset = 1'b0;
      chk($sformatf("clear2_%0d", k), 8'hCC, (k > 5) ? 8'h00 : 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    Reset = 1'b1;
    n_checks++;
    if (ClearDone !== 1'b0 || Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_direct: rdy=%b done=%b", Ready, ClearDone);
    end
    chk("abort_ready", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    read_all_zero("after_abort");

    // Same-cycle forwarding (or its absence).
    WriteEn = 1'b1; Waddr = 4'd9; DataIn = 8'h5C; RaddrA = 4'd9; RaddrB = 4'd9;
    chk("bypass_same", BYP ? 8'h5C : 8'h00, BYP ? 8'h5C : 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    WriteEn = 1'b0;
    n_checks++;
    if (DataOutA !== 8'h5C || DataOutB !== 8'h5C) begin
      n_fail++;
      $display("FAIL bypass_next_direct: A=%02h B=%02h", DataOutA, DataOutB);
    end
    chk("bypass_next", 8'h5C, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Drain with a bounded wait; anything left was never compared.
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never compared", e.name, e.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
